// File: rtl/fp_square_pkg.sv
// Shared constants, rounding-mode codes and FSM state encoding for the fp_square squarer.
// Build option: FP_SQUARE_RADIX4_EN selects the two-bit-per-cycle multiplier.
package fp_square_pkg;

   localparam int W = 32;
   localparam int M = 22;
   localparam int E = 30;

   localparam logic [W-1:0] FP_NANQ  = 32'h7FC0_0000;
   localparam logic [W-1:0] FP_NANS  = 32'h7FA0_0000;
   localparam logic [W-1:0] FP_INFP  = 32'h7F80_0000;
   localparam logic [W-1:0] FP_MAXP  = 32'h7F7F_FFFF;
   localparam logic [W-1:0] FP_ZEROP = 32'h0000_0000;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RZ  = 3'd1;
   localparam logic [2:0] RM_RD  = 3'd2;
   localparam logic [2:0] RM_RU  = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RND  = 2'd2,
      ST_SPEC = 2'd3
   } state_t;

   // Result is always positive, so RD behaves like RZ and RU like "away from zero".
   function automatic logic round_inc(input logic [2:0] rm, input logic lsb,
                                      input logic g, input logic t);
      case (rm)
         RM_RNE:  return g & (t | lsb);
         RM_RU:   return g | t;
         RM_RMM:  return g;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fp_square_if.sv
// act/done handshake bundle between a requester (master) and the fp_square unit (slave).
interface fp_square_if;
   logic                       act;
   logic [fp_square_pkg::W-1:0] in1;
   logic [2:0]                 round_m;
   logic [fp_square_pkg::W-1:0] out;
   logic                       busy;
   logic                       done;
   logic                       ov;
   logic                       un;
   logic                       inv;
   logic                       inexact;

   modport slave  (input  act, in1, round_m,
                   output out, busy, done, ov, un, inv, inexact);
   modport master (output act, in1, round_m,
                   input  out, busy, done, ov, un, inv, inexact);
endinterface

// File: rtl/fp_seq_mul.sv
// 24x24 unsigned iterative shift-add multiplier; FP_SQUARE_RADIX4_EN retires two multiplier bits per cycle.
module fp_seq_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [23:0] i_a,
   input  logic [23:0] i_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [47:0] o_prod
);
`ifdef FP_SQUARE_RADIX4_EN
   localparam int         STEP = 2;
   localparam logic [4:0] LAST = 5'd11;
`else
   localparam int         STEP = 1;
   localparam logic [4:0] LAST = 5'd23;
`endif

   logic [47:0] r_mcand;
   logic [47:0] r_acc;
   logic [23:0] r_mplier;
   logic [4:0]  r_cnt;
   logic        r_busy;
   logic [47:0] w_addend;

   always_comb begin
      w_addend = '0;
`ifdef FP_SQUARE_RADIX4_EN
      case (r_mplier[1:0])
         2'd1:    w_addend = r_mcand;
         2'd2:    w_addend = r_mcand << 1;
         2'd3:    w_addend = r_mcand + (r_mcand << 1);
         default: w_addend = '0;
      endcase
`else
      if (r_mplier[0]) w_addend = r_mcand;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= {24'd0, i_a};
         r_acc    <= '0;
         r_mplier <= i_b;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= r_acc + w_addend;
         r_mcand  <= r_mcand << STEP;
         r_mplier <= r_mplier >> STEP;
         r_cnt    <= r_cnt + 5'd1;
         if (r_cnt == LAST) r_busy <= 1'b0;
      end
   end

   // Pulses on the cycle whose closing edge adds the final partial product.
   assign o_done = r_busy && (r_cnt == LAST);
   assign o_busy = r_busy;
   assign o_prod = r_acc;

endmodule

// File: rtl/fp_square.sv
// IEEE-754 single-precision squarer: special decode, exponent, normalise/round, registered result and flags.
// Latency 25 by default, 13 with FP_SQUARE_RADIX4_EN defined (via fp_seq_mul).
//   state   | meaning
//   IDLE    | waiting for act
//   MUL     | mantissa product in progress
//   RND     | normalise, round, register out/flags, pulse done
//   SPEC    | NaN/inf/zero/subnormal operand, result in one cycle
module fp_square
   import fp_square_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   fp_square_if.slave bus
);
   state_t         r_state;
   logic [W-2:0]   r_opnd;
   logic [2:0]     r_rm;
   logic [W-1:0]   r_out;
   logic           r_busy, r_done, r_ov, r_un, r_inv, r_inexact;

   logic [7:0]        w_in_e;
   logic              w_in_special, w_accept, w_mul_busy, w_mul_done;
   logic [47:0]       w_prod;
   logic [7:0]        w_e;
   logic [M:0]        w_f;
   logic signed [9:0] w_er_n, w_er_f;
   logic [M:0]        w_frac, w_frac_r;
   logic              w_g, w_t, w_inc;
   logic [M+1:0]      w_sum;
   logic [W-1:0]      w_rnd_out, w_spec_out;
   logic              w_rnd_ov, w_rnd_un, w_rnd_inexact, w_spec_inv, w_spec_un;

   assign w_in_e       = bus.in1[E:M+1];
   assign w_in_special = (w_in_e == 8'hFF) || (w_in_e == 8'h00);
   assign w_accept     = (r_state == ST_IDLE) && bus.act && !w_mul_busy;

   fp_seq_mul u_mul (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_accept && !w_in_special),
      .i_a     ({1'b1, bus.in1[M:0]}),
      .i_b     ({1'b1, bus.in1[M:0]}),
      .o_busy  (w_mul_busy),
      .o_done  (w_mul_done),
      .o_prod  (w_prod)
   );

   assign w_e = r_opnd[E:M+1];
   assign w_f = r_opnd[M:0];

   always_comb begin
      w_er_n = $signed({1'b0, w_e, 1'b0}) - 10'sd127;
      if (w_prod[47]) begin
         w_frac = w_prod[46:24];
         w_g    = w_prod[23];
         w_t    = |w_prod[22:0];
         w_er_n = w_er_n + 10'sd1;
      end else begin
         w_frac = w_prod[45:23];
         w_g    = w_prod[22];
         w_t    = |w_prod[21:0];
      end
      w_inc    = round_inc(r_rm, w_frac[0], w_g, w_t);
      w_sum    = {1'b0, w_frac} + {{M+1{1'b0}}, w_inc};
      w_frac_r = w_sum[M:0];
      w_er_f   = w_sum[M+1] ? w_er_n + 10'sd1 : w_er_n;

      w_rnd_ov      = 1'b0;
      w_rnd_un      = 1'b0;
      w_rnd_inexact = w_g | w_t;
      w_rnd_out     = {1'b0, w_er_f[7:0], w_frac_r};
      if (w_er_f >= 10'sd255) begin
         w_rnd_ov      = 1'b1;
         w_rnd_inexact = 1'b1;
         w_rnd_out     = (r_rm == RM_RZ || r_rm == RM_RD) ? FP_MAXP : FP_INFP;
      end else if (w_er_f <= 10'sd0) begin
         w_rnd_un      = 1'b1;
         w_rnd_inexact = 1'b1;
         w_rnd_out     = FP_ZEROP;
      end
   end

   always_comb begin
      w_spec_out = FP_ZEROP;
      w_spec_inv = 1'b0;
      w_spec_un  = 1'b0;
      if (w_e == 8'hFF) begin
         w_spec_out = (w_f == '0) ? FP_INFP : FP_NANQ;
         w_spec_inv = (w_f != '0) && !w_f[M];
      end else begin
         w_spec_un  = (w_f != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_opnd    <= '0;
         r_rm      <= '0;
         r_out     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ov      <= 1'b0;
         r_un      <= 1'b0;
         r_inv     <= 1'b0;
         r_inexact <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_opnd  <= bus.in1[W-2:0];
               r_rm    <= bus.round_m;
               r_busy  <= 1'b1;
               r_state <= w_in_special ? ST_SPEC : ST_MUL;
            end
            ST_MUL: if (w_mul_done) r_state <= ST_RND;
            ST_RND: begin
               r_out     <= w_rnd_out;
               r_ov      <= w_rnd_ov;
               r_un      <= w_rnd_un;
               r_inv     <= 1'b0;
               r_inexact <= w_rnd_inexact;
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
            ST_SPEC: begin
               r_out     <= w_spec_out;
               r_ov      <= 1'b0;
               r_un      <= w_spec_un;
               r_inv     <= w_spec_inv;
               r_inexact <= w_spec_un;
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.out     = r_out;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.ov      = r_ov;
   assign bus.un      = r_un;
   assign bus.inv     = r_inv;
   assign bus.inexact = r_inexact;

endmodule

// File: tb/tb_fp_square.sv
// Directed scoreboard bench for fp_square; expected results queued at accept, checked on done.
module tb_fp_square;
   import fp_square_pkg::*;

`ifdef FP_SQUARE_RADIX4_EN
   localparam int LAT = 13;
`else
   localparam int LAT = 25;
`endif

   typedef struct {
      string       tag;
      logic [31:0] out;
      logic [3:0]  flags;
      int          k;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_square_if bus ();
   fp_square dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   dones    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         dones++;
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL spurious_done got=done exp=no_done cyc=%0d", cyc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (bus.out === e.out) else begin
               failures++;
               $error("FAIL %s.out got=%h exp=%h", e.tag, bus.out, e.out);
            end
            checks++;
            assert ({bus.ov, bus.un, bus.inv, bus.inexact} === e.flags) else begin
               failures++;
               $error("FAIL %s.flags got=%b exp=%b", e.tag,
                      {bus.ov, bus.un, bus.inv, bus.inexact}, e.flags);
            end
            checks++;
            assert ((cyc - e.k) == e.lat) else begin
               failures++;
               $error("FAIL %s.latency got=%0d exp=%0d", e.tag, cyc - e.k, e.lat);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         step();
         n++;
      end
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL %s.timeout got=pending exp=done", tag);
      end
      sb.delete();
   endtask

   task automatic launch(input string tag, input logic [31:0] a, input logic [2:0] rm,
                         input logic [31:0] eo, input logic [3:0] ef, input int lat);
      step();
      bus.act     = 1'b1;
      bus.in1     = a;
      bus.round_m = rm;
      sb.push_back('{tag, eo, ef, cyc + 1, lat});
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [2:0] rm,
                     input logic [31:0] eo, input logic [3:0] ef, input int lat);
      launch(tag, a, rm, eo, ef, lat);
      step();
      bus.act = 1'b0;
      wait_drain(tag);
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      assert (bus.out === 32'h0 && bus.busy === 1'b0 && bus.done === 1'b0 &&
              {bus.ov, bus.un, bus.inv, bus.inexact} === 4'b0) else begin
         failures++;
         $error("FAIL %s got=out %h busy %b done %b flags %b exp=all_zero", tag, bus.out,
                bus.busy, bus.done, {bus.ov, bus.un, bus.inv, bus.inexact});
      end
   endtask

   initial begin
      int d0;
      bus.act     = 1'b0;
      bus.in1     = '0;
      bus.round_m = RM_RNE;
      idle(2);
      check_idle_outputs("reset_state");
      rst = 1'b0;
      idle(2);

      // flags = {ov, un, inv, inexact}
      op("sq3_rne",     32'h4040_0000, RM_RNE, 32'h4110_0000, 4'b0000, LAT);
      op("ulp_rne",     32'h3F80_0001, RM_RNE, 32'h3F80_0002, 4'b0001, LAT);
      op("ulp_ru",      32'h3F80_0001, RM_RU,  32'h3F80_0003, 4'b0001, LAT);
      op("ulp_rz",      32'h3F80_0001, RM_RZ,  32'h3F80_0002, 4'b0001, LAT);
      op("ulp_rd",      32'h3F80_0001, RM_RD,  32'h3F80_0002, 4'b0001, LAT);
      op("ulp_rmm",     32'h3F80_0001, RM_RMM, 32'h3F80_0002, 4'b0001, LAT);
      op("one",         32'h3F80_0000, RM_RNE, 32'h3F80_0000, 4'b0000, LAT);
      op("ones_rne",    32'h3FFF_FFFF, RM_RNE, 32'h407F_FFFE, 4'b0001, LAT);
      op("ones_ru",     32'h3FFF_FFFF, RM_RU,  32'h407F_FFFF, 4'b0001, LAT);
      op("ovf_rne",     32'h5F80_0000, RM_RNE, FP_INFP,       4'b1001, LAT);
      op("ovf_rz",      32'h5F80_0000, RM_RZ,  FP_MAXP,       4'b1001, LAT);
      op("ovf_ru",      32'h5F80_0000, RM_RU,  FP_INFP,       4'b1001, LAT);
      op("ovf_rd",      32'h5F80_0000, RM_RD,  FP_MAXP,       4'b1001, LAT);
      op("nearmax_rne", 32'h5F7F_FFFF, RM_RNE, 32'h7F7F_FFFE, 4'b0001, LAT);
      op("nearmax_ru",  32'h5F7F_FFFF, RM_RU,  32'h7F7F_FFFF, 4'b0001, LAT);
      op("minnorm",     32'h2000_0000, RM_RNE, 32'h0080_0000, 4'b0000, LAT);
      op("unf",         32'h1F80_0000, RM_RNE, FP_ZEROP,      4'b0101, LAT);
      op("unf_ones_ru", 32'h1FFF_FFFF, RM_RU,  FP_ZEROP,      4'b0101, LAT);
      op("neg3",        32'hC040_0000, RM_RNE, 32'h4110_0000, 4'b0000, LAT);
      op("snan",        FP_NANS,       RM_RNE, FP_NANQ,       4'b0010, 1);
      op("qnan",        32'h7FC0_0000, RM_RNE, FP_NANQ,       4'b0000, 1);
      op("ninf",        32'hFF80_0000, RM_RNE, FP_INFP,       4'b0000, 1);
      op("nzero",       32'h8000_0000, RM_RNE, FP_ZEROP,      4'b0000, 1);
      op("subn",        32'h0000_0001, RM_RNE, FP_ZEROP,      4'b0101, 1);
      op("nsubn",       32'h807F_FFFF, RM_RZ,  FP_ZEROP,      4'b0101, 1);

      // act held through two back-to-back operations: exactly two dones
      d0 = dones;
      launch("held_a", 32'h4040_0000, RM_RNE, 32'h4110_0000, 4'b0000, LAT);
      wait_drain("held_a");
      bus.in1 = 32'h3F80_0001;
      sb.push_back('{"held_b", 32'h3F80_0002, 4'b0001, cyc + 1, LAT});
      wait_drain("held_b");
      bus.act = 1'b0;
      idle(LAT + 5);
      checks++;
      assert (dones - d0 == 2) else begin
         failures++;
         $error("FAIL held_done_count got=%0d exp=2", dones - d0);
      end

      // second act pulse while busy is ignored
      d0 = dones;
      launch("busy_ign", 32'h4040_0000, RM_RNE, 32'h4110_0000, 4'b0000, LAT);
      step();
      bus.act = 1'b0;
      idle(4);
      bus.act = 1'b1;
      bus.in1 = 32'h5F80_0000;
      step();
      bus.act = 1'b0;
      wait_drain("busy_ign");
      idle(LAT + 5);
      checks++;
      assert (dones - d0 == 1) else begin
         failures++;
         $error("FAIL busy_ign_done_count got=%0d exp=1", dones - d0);
      end

      // reset during MUL abandons the operation
      d0 = dones;
      launch("rst_mid", 32'h4040_0000, RM_RU, 32'h4110_0000, 4'b0000, LAT);
      step();
      bus.act = 1'b0;
      idle(9);
      checks++;
      assert (bus.busy === 1'b1) else begin
         failures++;
         $error("FAIL rst_mid_busy got=%b exp=1", bus.busy);
      end
      rst = 1'b1;
      #1;
      check_idle_outputs("rst_mid_outputs");
      sb.delete();
      idle(3);
      rst = 1'b0;
      idle(LAT + 5);
      checks++;
      assert (dones == d0) else begin
         failures++;
         $error("FAIL rst_no_done got=%0d exp=0", dones - d0);
      end
      op("after_rst", 32'h4040_0000, RM_RNE, 32'h4110_0000, 4'b0000, LAT);

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
